// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding,
// default operand width and the signed-overflow helper.
package serial_addsub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Signed overflow: carry into the MSB disagrees with carry out of the MSB.
   function automatic logic signed_ovf(input logic c_in_msb, input logic c_out_msb);
      return c_in_msb ^ c_out_msb;
   endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// Single-bit full adder cell: the only arithmetic slice of the serial datapath.
module serial_addsub_full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic c_out,
   output logic s
);

   assign s     = a ^ b ^ c;
   assign c_out = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor. One bit per clock, LSB first, using a
// single full-adder slice. Subtraction is A + ~B + 1: B is inverted and the
// carry flop is preset to 1 when the operation is accepted.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow
);

   localparam int                CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state_r;
   logic [WIDTH-1:0]   opa_r;
   logic [WIDTH-1:0]   opb_r;
   logic [WIDTH-1:0]   acc_r;
   logic               carry_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               fa_sum_s;
   logic               fa_carry_s;
   logic               accept_s;

   serial_addsub_full_adder u_fa (
      .a     (opa_r[0]),
      .b     (opb_r[0]),
      .c     (carry_r),
      .c_out (fa_carry_s),
      .s     (fa_sum_s)
   );

   // A new operation is taken only when no operation is in flight (IDLE or DONE).
   always_comb begin
      accept_s = 1'b0;
      if (start && ((state_r == S_IDLE) || (state_r == S_DONE))) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // FSM, serial datapath and registered outputs in one clocked process.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= S_IDLE;
         opa_r    <= '0;
         opb_r    <= '0;
         acc_r    <= '0;
         carry_r  <= 1'b0;
         cnt_r    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept_s) begin
            state_r <= S_SHIFT;
            opa_r   <= a;
            opb_r   <= sub ? ~b : b;
            carry_r <= sub;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b1;
         end else begin
            case (state_r)
               S_IDLE: begin
                  state_r <= S_IDLE;
                  busy    <= 1'b0;
               end
               S_SHIFT: begin
                  acc_r   <= {fa_sum_s, acc_r[WIDTH-1:1]};
                  opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
                  opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
                  carry_r <= fa_carry_s;
                  cnt_r   <= cnt_r + CNT_ONE;
                  if (cnt_r == LAST_CNT) begin
                     // carry_r is the carry into the MSB on this final bit.
                     state_r  <= S_DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     result   <= {fa_sum_s, acc_r[WIDTH-1:1]};
                     c_out    <= fa_carry_s;
                     overflow <= signed_ovf(carry_r, fa_carry_s);
                  end else begin
                     state_r <= S_SHIFT;
                     busy    <= 1'b1;
                  end
               end
               S_DONE: begin
                  state_r <= S_IDLE;
                  busy    <= 1'b0;
               end
               default: begin
                  state_r <= S_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed vectors, ignored
// start while busy, back-to-back start, reset abort and random operations.
module tb_serial_addsub;

   localparam int W = 8;

   typedef logic [W+1:0] res_t;   // {overflow, c_out, result}

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         c_out;
   logic         overflow;

   res_t exp_q[$];
   res_t hold_exp = '0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W-1:0] yy;
      logic [W:0]   sum;
      logic         ov;
      yy  = s ? ~y : y;
      sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
      ov  = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
      return {ov, sum[W], sum[W-1:0]};
   endfunction

   // Scoreboard: compare at each done pulse, otherwise outputs must hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               hold_exp = exp_q.pop_front();
               chk("result", {22'd0, overflow, c_out, result}, {22'd0, hold_exp});
            end
         end else begin
            chk("stable", {22'd0, overflow, c_out, result}, {22'd0, hold_exp});
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_wait", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_outs", {22'd0, overflow, c_out, result}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_q.delete();
      hold_exp = '0;
      check_reset_outputs();
      rst_n = 1'b1;
   endtask

   // Issue one operation; optionally drive a junk start at cycle junk_at of SHIFT.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input int junk_at, input res_t e);
      int lat = 0;
      wait_idle();
      a = ia; b = ib; sub = is; start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_acc", {31'd0, busy}, 32'd1);
      for (int n = 1; n <= 2 * W; n++) begin
         if (n == junk_at) begin
            a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = n;
            break;
         end
         chk("busy_run", {31'd0, busy}, 32'd1);
      end
      start = 1'b0;
      chk("latency", lat, W);
   endtask

   // Start an operation and reset it in its 4th SHIFT cycle.
   task automatic abort_op();
      wait_idle();
      a = 8'd77; b = 8'd11; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      hold_exp = '0;
      check_reset_outputs();
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      do_reset();
      do_op(8'd25,  8'd17,  1'b0, 0, {1'b0, 1'b0, 8'd42});
      do_op(8'd200, 8'd100, 1'b0, 0, {1'b0, 1'b1, 8'd44});
      do_op(8'd100, 8'd100, 1'b0, 0, {1'b1, 1'b0, 8'd200});
      do_op(8'd5,   8'd9,   1'b1, 0, {1'b0, 1'b0, 8'd252});
      do_op(8'h80,  8'h01,  1'b1, 0, {1'b1, 1'b1, 8'h7F});
      do_op(8'd25,  8'd17,  1'b0, 3, {1'b0, 1'b0, 8'd42});
      do_op(8'd5,   8'd9,   1'b1, 0, {1'b0, 1'b0, 8'd252});
      abort_op();
      do_op(8'd25,  8'd17,  1'b0, 0, {1'b0, 1'b0, 8'd42});
      for (int i = 0; i < 1000; i++) begin
         x = 8'($urandom_range(0, 255));
         y = 8'($urandom_range(0, 255));
         s = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
         end
         do_op(x, y, s, (i % 7 == 0) ? 2 : 0, model(x, y, s));
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
